// File: rtl/argon_lsu_pkg.sv
// Shared types for the Argon load/store unit: access sizes, fault codes and FSM states.
package argon_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2,
    FAULT_SIZE     = 2'd3
  } lsu_fault_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_FAULT
  } lsu_state_t;

  function automatic int unsigned size_bytes(input lsu_size_t size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/argon_lsu_if.sv
// Data memory port between the load/store unit (master) and memory (slave).
interface argon_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wr_data;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rd_data;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wr_data,
    input  mem_ready, mem_rd_data
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wr_data,
    output mem_ready, mem_rd_data
  );
endinterface

// File: rtl/argon_lsu_lane.sv
// Byte-lane steering: store byte enables / replicated write data, and load shift + extend.
module argon_lsu_lane
  import argon_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int unsigned BE_W = DATA_W / 8,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  lsu_size_t           st_size,
  input  logic [LANE_W-1:0]   st_lane,
  input  logic [DATA_W-1:0]   st_wdata,
  output logic [BE_W-1:0]     st_be,
  output logic [DATA_W-1:0]   st_wr_data,
  input  lsu_size_t           ld_size,
  input  logic                ld_signed,
  input  logic [LANE_W-1:0]   ld_lane,
  input  logic [DATA_W-1:0]   ld_rd_data,
  output logic [DATA_W-1:0]   ld_data
);

  int unsigned       st_bytes;
  int unsigned       ld_bytes;
  logic [BE_W-1:0]   be_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  always_comb begin
    st_bytes = size_bytes(st_size);
    if (st_bytes > BE_W) st_bytes = BE_W;
    be_mask    = '0;
    st_wr_data = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      be_mask[i]          = (i < st_bytes);
      st_wr_data[8*i +: 8] = st_wdata[8*(i % st_bytes) +: 8];
    end
    st_be = be_mask << st_lane;
  end

  // Bytes above the access width are filled with the extension bit of the top kept byte.
  always_comb begin
    ld_bytes = size_bytes(ld_size);
    if (ld_bytes > BE_W) ld_bytes = BE_W;
    shifted  = ld_rd_data >> {ld_lane, 3'b000};
    sign_bit = ld_signed & shifted[8*ld_bytes - 1];
    ld_data  = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      ld_data[8*i +: 8] = (i < ld_bytes) ? shifted[8*i +: 8] : {8{sign_bit}};
    end
  end

endmodule

// File: rtl/argon_lsu.sv
// Argon load/store unit: one access at a time, ready-handshaked memory port, fault reporting.
module argon_lsu
  import argon_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_halt,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [1:0]         i_size,
  input  logic               i_signed,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic [DATA_W-1:0]  o_rdata,
  output logic               o_fault,
  output logic [1:0]         o_fault_code,
  argon_lsu_if.master        mem
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

  lsu_state_t         state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               done_q;
  logic               fault_q;
  lsu_fault_t         fault_code_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [BE_W-1:0]    mem_be_q;
  logic [DATA_W-1:0]  mem_wr_data_q;
  lsu_size_t          ld_size_q;
  logic               ld_signed_q;
  logic [LANE_W-1:0]  ld_lane_q;

  lsu_size_t          req_size;
  logic [2:0]         align_mask;
  logic               size_bad;
  logic               misaligned;
  logic               timeout_hit;
  logic [BE_W-1:0]    lane_be;
  logic [DATA_W-1:0]  lane_wr_data;
  logic [DATA_W-1:0]  lane_ld_data;

  assign req_size = lsu_size_t'(i_size);

  always_comb begin
    align_mask = 3'b000;
    unique case (req_size)
      SIZE_B: align_mask = 3'b000;
      SIZE_H: align_mask = 3'b001;
      SIZE_W: align_mask = 3'b011;
      SIZE_D: align_mask = 3'b111;
    endcase
  end

  assign size_bad    = (req_size == SIZE_D) && (DATA_W != 64);
  assign misaligned  = |(i_addr[2:0] & align_mask);
  // The count that would be reached this cycle is compared, so mem_req spans exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  argon_lsu_lane #(
    .DATA_W (DATA_W)
  ) u_lane (
    .st_size    (req_size),
    .st_lane    (i_addr[LANE_W-1:0]),
    .st_wdata   (i_wdata),
    .st_be      (lane_be),
    .st_wr_data (lane_wr_data),
    .ld_size    (ld_size_q),
    .ld_signed  (ld_signed_q),
    .ld_lane    (ld_lane_q),
    .ld_rd_data (mem.mem_rd_data),
    .ld_data    (lane_ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FAULT_NONE;
      rdata_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wr_data_q <= '0;
      ld_size_q     <= SIZE_B;
      ld_signed_q   <= 1'b0;
      ld_lane_q     <= '0;
    end else if (!i_halt) begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_req) begin
            if (size_bad) begin
              state        <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_SIZE;
            end else if (misaligned) begin
              state        <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_MISALIGN;
            end else begin
              state         <= ST_ACCESS;
              wait_cnt      <= '0;
              mem_req_q     <= 1'b1;
              mem_we_q      <= i_we;
              mem_addr_q    <= i_addr & ALIGN_MASK;
              mem_be_q      <= lane_be;
              mem_wr_data_q <= lane_wr_data;
              ld_size_q     <= req_size;
              ld_signed_q   <= i_signed;
              ld_lane_q     <= i_addr[LANE_W-1:0];
            end
          end
        end
        ST_ACCESS: begin
          if (mem.mem_ready) begin
            mem_req_q <= 1'b0;
            if (!mem_we_q) rdata_q <= lane_ld_data;
            state  <= ST_RESP;
            done_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit) begin
              mem_req_q    <= 1'b0;
              state        <= ST_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= FAULT_TIMEOUT;
            end
          end
        end
        ST_RESP:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (state != ST_IDLE);
  assign o_done       = done_q;
  assign o_rdata      = rdata_q;
  assign o_fault      = fault_q;
  assign o_fault_code = fault_code_q;

  assign mem.mem_req     = mem_req_q;
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_be      = mem_be_q;
  assign mem.mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_argon_lsu.sv
// Directed bench for argon_lsu (DATA_W = 32, TIMEOUT = 4) with hand-computed expectations.
module tb_argon_lsu;

  logic        clk;
  logic        i_reset_n;
  logic        i_halt;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_signed;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_fault;
  logic [1:0]  o_fault_code;

  int unsigned n_pass;
  int unsigned n_total;

  argon_lsu_if #(.DATA_W(32), .ADDR_W(32)) mem_if ();

  argon_lsu #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_halt       (i_halt),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_size       (i_size),
    .i_signed     (i_signed),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_fault      (o_fault),
    .o_fault_code (o_fault_code),
    .mem          (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge; afterwards the bench sits in the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i_req    = 1'b1;
    i_we     = we;
    i_size   = size;
    i_signed = sgn;
    i_addr   = addr;
    i_wdata  = wdata;
    step();
    i_req = 1'b0;
  endtask

  task automatic ready_pulse(input logic [31:0] rd);
    mem_if.mem_ready   = 1'b1;
    mem_if.mem_rd_data = rd;
    step();
    mem_if.mem_ready   = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_reset_n = 1'b0;
    i_halt    = 1'b0;
    i_req     = 1'b0;
    i_we      = 1'b0;
    i_size    = 2'd0;
    i_signed  = 1'b0;
    i_addr    = '0;
    i_wdata   = '0;
    mem_if.mem_ready   = 1'b0;
    mem_if.mem_rd_data = '0;

    step();
    step();
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_fault", {o_fault, o_fault_code}, 0);
    chk("rst_mem",   {mem_if.mem_req, mem_if.mem_we, mem_if.mem_be}, 0);
    chk("rst_addr",  mem_if.mem_addr, 0);
    chk("rst_wr",    mem_if.mem_wr_data, 0);
    chk("rst_rdata", o_rdata, 0);
    i_reset_n = 1'b1;
    step();

    // Load word, zero wait
    issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    chk("lw_req",  mem_if.mem_req, 1);
    chk("lw_addr", mem_if.mem_addr, 32'h104);
    chk("lw_be",   mem_if.mem_be, 4'b1111);
    chk("lw_we",   mem_if.mem_we, 0);
    chk("lw_busy", o_busy, 1);
    ready_pulse(32'hDEADBEEF);
    chk("lw_done",  o_done, 1);
    chk("lw_rdata", o_rdata, 32'hDEADBEEF);
    chk("lw_req_off", mem_if.mem_req, 0);
    step();
    chk("lw_done_pulse", o_done, 0);
    chk("lw_idle", o_busy, 0);

    // Signed byte load, lane 3
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    chk("lb_be",   mem_if.mem_be, 4'b1000);
    chk("lb_addr", mem_if.mem_addr, 32'h100);
    ready_pulse(32'h80112233);
    chk("lb_done",  o_done, 1);
    chk("lb_rdata", o_rdata, 32'hFFFFFF80);
    step();

    // Same access, unsigned
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    ready_pulse(32'h80112233);
    chk("lbu_rdata", o_rdata, 32'h00000080);
    step();

    // Signed half load, lane 2
    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    chk("lh_be", mem_if.mem_be, 4'b1100);
    ready_pulse(32'h80011234);
    chk("lh_rdata", o_rdata, 32'hFFFF8001);
    step();

    // Store half with 2 wait cycles: done in cycle 4
    issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD);
    chk("sh_be", mem_if.mem_be, 4'b1100);
    chk("sh_wr", mem_if.mem_wr_data, 32'hABCDABCD);
    chk("sh_we", mem_if.mem_we, 1);
    step();
    chk("sh_c2_done", o_done, 0);
    step();
    chk("sh_c3_req",  mem_if.mem_req, 1);
    chk("sh_c3_wr",   mem_if.mem_wr_data, 32'hABCDABCD);
    chk("sh_c3_done", o_done, 0);
    ready_pulse(32'h0);
    chk("sh_c4_done", o_done, 1);
    step();

    // Store byte at lane 1
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000005A);
    chk("sb_be",   mem_if.mem_be, 4'b0010);
    chk("sb_wr",   mem_if.mem_wr_data, 32'h5A5A5A5A);
    chk("sb_addr", mem_if.mem_addr, 32'h100);
    ready_pulse(32'h0);
    chk("sb_done", o_done, 1);
    step();

    // Misaligned word
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    chk("mis_fault", {o_fault, o_fault_code}, 3'b101);
    chk("mis_req",   mem_if.mem_req, 0);
    chk("mis_done",  o_done, 0);
    step();
    chk("mis_pulse", {o_fault, o_busy, mem_if.mem_req}, 0);

    // Dword on 32-bit path
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    chk("size_fault", {o_fault, o_fault_code}, 3'b111);
    chk("size_req",   mem_if.mem_req, 0);
    step();

    // Timeout: mem_req high cycles 1..4, fault in 5
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_req_c%0d", c), {mem_if.mem_req, o_fault}, 2'b10);
      step();
    end
    chk("to_fault", {o_fault, o_fault_code}, 3'b110);
    chk("to_req_off", mem_if.mem_req, 0);
    step();
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    chk("to_next_req", mem_if.mem_req, 1);
    ready_pulse(32'h12345678);
    chk("to_next_rdata", o_rdata, 32'h12345678);
    chk("to_next_done",  o_done, 1);
    step();

    // One wait cycle, then halt for 3: done moves from cycle 3 to cycle 6
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    step();
    i_halt = 1'b1;
    mem_if.mem_ready   = 1'b1;
    mem_if.mem_rd_data = 32'hCAFEF00D;
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("halt_c%0d_done", c), o_done, 0);
      step();
    end
    i_halt = 1'b0;
    chk("halt_c5_done", o_done, 0);
    chk("halt_c5_req",  mem_if.mem_req, 1);
    step();
    mem_if.mem_ready = 1'b0;
    chk("halt_c6_done",  o_done, 1);
    chk("halt_c6_rdata", o_rdata, 32'hCAFEF00D);
    step();

    // Reset mid-access
    issue(1'b1, 2'd2, 1'b0, 32'h500, 32'h11223344);
    chk("rma_req", mem_if.mem_req, 1);
    i_reset_n = 1'b0;
    step();
    i_reset_n = 1'b1;
    chk("rma_mem", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_be}, 0);
    chk("rma_addr_wr", {mem_if.mem_addr, mem_if.mem_wr_data}, 0);
    chk("rma_out", {o_busy, o_done, o_fault, o_fault_code}, 0);
    chk("rma_rdata", o_rdata, 0);
    mem_if.mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("rma_no_done%0d", c), {o_done, mem_if.mem_req, o_busy}, 0);
    end
    mem_if.mem_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/argon_lsu.md
# argon_lsu

Parametrised multi-cycle load/store unit for the Argon core, sitting between the control FSM's MEM stage and the data memory port. It accepts one access request at a time and generates byte enables and lane-replicated write data. It waits on a ready handshake for variable-latency memory and returns sign- or zero-extended load data. Misaligned addresses, unsupported sizes and memory timeouts are reported as faults instead of being silently issued.

## Interface
- DATA_W, 32, data path width; 32 or 64
- ADDR_W, 32, byte address width
- TIMEOUT, 255, maximum wait cycles with ready low before a timeout fault; 0 disables the timeout
- i_clk  in  1  system clock; all logic is on the rising edge
- i_reset_n  in  1  reset; one clock, synchronous, active-low
- i_halt  in  1  freeze: state, counters and all registered outputs hold
- i_req  in  1  access request; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64)
- i_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend
- i_addr  in  ADDR_W  byte address
- i_wdata  in  DATA_W  store data, right-justified
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_rdata  out  DATA_W  extended load data; valid with o_done, held until the next o_done
- o_fault  out  1  one-cycle fault pulse; never in the same cycle as o_done
- o_fault_code  out  2  1 = misaligned, 2 = timeout, 3 = bad size; valid with o_fault
- o_mem_req  out  1  memory request; held until accepted
- o_mem_we  out  1  memory write
- o_mem_addr  out  ADDR_W  address aligned down to DATA_W/8 bytes
- o_mem_be  out  DATA_W/8  byte enables
- o_mem_wr_data  out  DATA_W  lane-replicated store data
- i_mem_ready  in  1  accept/complete; level signal, sampled only while o_mem_req = 1
- i_mem_rd_data  in  DATA_W  read word; valid while i_mem_ready = 1

## Operation
- States: IDLE, ACCESS, RESP, FAULT.
- IDLE + i_req:
  - Bad size (size 3 when DATA_W = 32) → FAULT with code 3.
  - Else addr not a multiple of 2^size → FAULT with code 1.
  - Else latch all request fields → ACCESS.
- ACCESS: o_mem_req = 1. Address, we, be and wr_data stay stable until i_mem_ready is sampled high.
  - Ready high on a load → capture the lane-shifted, extended data, then go to RESP.
  - Ready high on a store → go to RESP.
  - Wait counter increments on every non-halted cycle with ready low. When the count equals TIMEOUT (nonzero), drop o_mem_req and go to FAULT with code 2.
- RESP: o_done = 1 for one cycle → IDLE.
- FAULT: o_fault = 1 for one cycle → IDLE. No memory request is ever issued for a code 1 or code 3 fault.
- Lane arithmetic:
  - lane = addr[log2(DATA_W/8)-1:0].
  - be = ((1 << 2^size) − 1) << lane.
  - wr_data = i_wdata[8·2^size−1:0] replicated across DATA_W.
  - Load: shift i_mem_rd_data right by 8·lane, keep 8·2^size bits, extend per i_signed.
- Requests arriving while o_busy = 1 are ignored and not queued.

## Timing
- Reset (i_reset_n low at an edge):
  - State goes to IDLE and the wait counter to 0.
  - o_busy, o_done, o_fault, o_fault_code, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wr_data and o_rdata all become 0.
  - Reset mid-ACCESS: o_mem_req drops in the next cycle and no o_done is produced.
- Zero-wait memory: i_req sampled at edge 0 → o_mem_req high in cycle 1. With ready high in cycle 1, o_done is high in cycle 2.
- With k ready-low cycles, load-to-done latency is 2 + k cycles.
- Fault latency: a code 1 or code 3 fault is signalled 1 cycle after the request.
- Timeout: o_mem_req stays high for exactly TIMEOUT cycles; o_fault follows in the next cycle.
- Halt: while i_halt is high, nothing advances, i_mem_ready is not sampled and the counter freezes. Memory keeps ready and data stable until it is sampled.
- Reset has priority over halt.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP or FAULT, giving a minimum of 3 cycles per access.

## Structure
- argon_pkg holds:
  - lsu_size_t (SIZE_B, SIZE_H, SIZE_W, SIZE_D)
  - lsu_fault_t (FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT, FAULT_SIZE)
  - lsu_state_t
- Sub-module argon_lsu_lane: combinational be/wr_data generation and load shift/extend, parametrised by DATA_W.
- argon_lsu keeps the FSM, the wait counter and the request/response registers.

## Test plan
- DATA_W = 32, load word at 0x104, memory returns 0xDEADBEEF with ready in cycle 1 → o_mem_addr 0x104, be 4'b1111, o_done in cycle 2, o_rdata 0xDEADBEEF.
- Signed byte load at 0x103 with rd_data 0x80112233 → be 4'b1000, o_rdata 0xFFFFFF80. The same access unsigned → 0x00000080.
- Store half at 0x102, wdata 0x0000ABCD → be 4'b1100, wr_data 0xABCDABCD, o_mem_we 1, o_done with 2 wait cycles at cycle 4.
- Load word at 0x102 → o_fault code 1 in cycle 1, o_mem_req never high. Size 3 with DATA_W = 32 → code 3.
- TIMEOUT = 4, ready never asserted → o_mem_req high in cycles 1–4, o_fault code 2 in cycle 5, then a new request is accepted.
- Halt held for 3 cycles mid-wait → latency extends by exactly 3. i_reset_n low mid-ACCESS → all outputs 0 the next cycle and no o_done.
